// File: rtl/sram_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sram_ctrl_pkg
// Shared constants for the SRAM burst controller:
//   - CMD_* : 2-bit command encodings on the cmd bus
//   - RD_PIPE_DEPTH : clocks from the sampling edge of a READ to rd_valid
//   - mem_width() : macro word width (data bits plus optional parity bit)
// Configuration macro: SRAM_PARITY_EN adds one even-parity bit per word.
// -----------------------------------------------------------------------------
package sram_ctrl_pkg;

    localparam logic [1:0] CMD_ADDR_LO = 2'b00;
    localparam logic [1:0] CMD_ADDR_HI = 2'b01;
    localparam logic [1:0] CMD_WRITE   = 2'b10;
    localparam logic [1:0] CMD_READ    = 2'b11;

    // One clock for the macro to read (E1), one to capture into rd_data (E2).
    localparam int RD_PIPE_DEPTH = 2;

`ifdef SRAM_PARITY_EN
    localparam int PARITY_W = 1;
`else
    localparam int PARITY_W = 0;
`endif

    function automatic int mem_width(input int data_w);
        return data_w + PARITY_W;
    endfunction

endpackage

// File: rtl/sram_ctrl_addr_ctr.sv
// -----------------------------------------------------------------------------
// sram_ctrl_addr_ctr
// ADDR_W-bit address pointer of the SRAM burst controller.
//   - i_load_lo : ptr[min(DATA_W,ADDR_W)-1:0] <= i_data
//   - i_load_hi : ptr[ADDR_W-1:DATA_W] <= i_data low bits (no-op if ADDR_W <= DATA_W)
//   - i_inc     : ptr <= ptr + 1, wrapping from DEPTH-1 to 0
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   i_load_lo   load low address field
//   i_load_hi   load high address field
//   i_inc       post-increment after an access
//   i_data      DATA_W load value
//   o_ptr       current pointer
// The three controls come from one decoded command and are mutually exclusive.
// -----------------------------------------------------------------------------
module sram_ctrl_addr_ctr #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load_lo,
    input  logic              i_load_hi,
    input  logic              i_inc,
    input  logic [DATA_W-1:0] i_data,
    output logic [ADDR_W-1:0] o_ptr
);

    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_lo_ptr;   // pointer with the low field replaced
    logic [ADDR_W-1:0] w_hi_ptr;   // pointer with the high field replaced

    // Per-bit selection keeps every index in range for any legal
    // DATA_W/ADDR_W pair: bits below DATA_W belong to the low field, bits at
    // or above it to the high field (which is empty when ADDR_W <= DATA_W).
    for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_bit
        if (gi < DATA_W) begin : g_lo_field
            assign w_lo_ptr[gi] = i_data[gi];
            assign w_hi_ptr[gi] = r_ptr[gi];
        end else begin : g_hi_field
            assign w_lo_ptr[gi] = r_ptr[gi];
            assign w_hi_ptr[gi] = i_data[gi-DATA_W];
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_load_lo) begin
            r_ptr <= w_lo_ptr;
        end else if (i_load_hi) begin
            r_ptr <= w_hi_ptr;
        end else if (i_inc) begin
            r_ptr <= r_ptr + ADDR_W'(1);   // natural wrap at DEPTH-1
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/sram_burst_ctrl.sv
// -----------------------------------------------------------------------------
// sram_burst_ctrl
// Command front-end for the single-port IHP SRAM macro (RM_IHPSG13_1P_*).
// Decodes a 2-bit command stream into macro accesses with two-phase address
// load, auto-increment bursts, a held read-data register and a read strobe.
// The macro's A_BM/A_DLY/BIST pins are tied off in the wrapper above this.
//
// Configuration macro: SRAM_PARITY_EN
//   defined   : MEM_W = DATA_W+1, even parity stored and checked on reads
//   undefined : MEM_W = DATA_W, rd_perr tied 0
//
// Ports:
//   clk, rst_n  clock (also macro A_CLK), asynchronous active-low reset
//   ena         block enable, registered onto mem_men
//   cmd_valid   command strobe, sampled each rising edge
//   cmd         00 ADDR_LO, 01 ADDR_HI, 10 WRITE, 11 READ
//   cmd_data    address field or write data
//   rd_data     last read word, held until the next read completes
//   rd_valid    one-cycle pulse, rd_data updated this cycle
//   rd_perr     parity error qualifying rd_valid (0 when rd_valid=0)
//   cur_addr    current address pointer
//   mem_men/mem_wen/mem_ren/mem_addr/mem_din -> macro A_MEN/A_WEN/A_REN/A_ADDR/A_DIN
//   mem_dout    <- macro A_DOUT
//
// Timing: a command sampled at edge E0 drives the macro pins during E0..E1,
// the macro acts at E1, and read data is captured into rd_data at E2.
// -----------------------------------------------------------------------------
module sram_burst_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int ADDR_W = 8,
    localparam int MEM_W  = mem_width(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_perr,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              mem_men,
    output logic              mem_wen,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [MEM_W-1:0]  mem_din,
    input  logic [MEM_W-1:0]  mem_dout
);

    // ------------------------------------------------------------------
    // Command decode
    // ------------------------------------------------------------------
    logic w_is_lo;
    logic w_is_hi;
    logic w_is_wr;
    logic w_is_rd;

    assign w_is_lo = cmd_valid && (cmd == CMD_ADDR_LO);
    assign w_is_hi = cmd_valid && (cmd == CMD_ADDR_HI);
    assign w_is_wr = cmd_valid && (cmd == CMD_WRITE);
    assign w_is_rd = cmd_valid && (cmd == CMD_READ);

    // ------------------------------------------------------------------
    // Address pointer
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] w_ptr;

    sram_ctrl_addr_ctr #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_addr_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load_lo (w_is_lo),
        .i_load_hi (w_is_hi),
        .i_inc     (w_is_wr || w_is_rd),
        .i_data    (cmd_data),
        .o_ptr     (w_ptr)
    );

    assign cur_addr = w_ptr;

    // ------------------------------------------------------------------
    // Parity generation / check
    // ------------------------------------------------------------------
    logic [MEM_W-1:0] w_din;
    logic             w_perr;

`ifdef SRAM_PARITY_EN
    assign w_din  = {^cmd_data, cmd_data};   // even parity over the word
    assign w_perr = ^mem_dout;               // odd total means a flipped bit
`else
    assign w_din  = cmd_data;
    assign w_perr = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Macro interface and read pipeline
    // ------------------------------------------------------------------
    // r_rd_pipe[0] is the registered A_REN (macro reads at E1); the last
    // stage marks the edge (E2) at which A_DOUT is captured into rd_data.
    logic                     r_mem_men;
    logic                     r_mem_wen;
    logic [ADDR_W-1:0]        r_mem_addr;
    logic [MEM_W-1:0]         r_mem_din;
    logic [RD_PIPE_DEPTH-1:0] r_rd_pipe;
    logic [DATA_W-1:0]        r_rd_data;
    logic                     r_rd_valid;
    logic                     w_rd_capture;

    assign w_rd_capture = r_rd_pipe[RD_PIPE_DEPTH-1];

    // NOTE: clearing the read pipeline in reset is what drops an in-flight
    // read; rd_data is reset too so nothing stale survives a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_men  <= 1'b0;
            r_mem_wen  <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_rd_pipe  <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_mem_men  <= ena;
            r_mem_wen  <= w_is_wr;
            r_rd_pipe  <= {r_rd_pipe[RD_PIPE_DEPTH-2:0], w_is_rd};
            r_rd_valid <= w_rd_capture;

            // Address is latched with the access, so an ADDR_* in the next
            // cycle only moves the pointer, never the access in flight.
            if (w_is_wr || w_is_rd) begin
                r_mem_addr <= w_ptr;
            end
            if (w_is_wr) begin
                r_mem_din <= w_din;
            end
            if (w_rd_capture) begin
                r_rd_data <= mem_dout[DATA_W-1:0];
            end
        end
    end

`ifdef SRAM_PARITY_EN
    logic r_rd_perr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_perr <= 1'b0;
        end else begin
            r_rd_perr <= w_rd_capture && w_perr;
        end
    end

    assign rd_perr = r_rd_perr;
`else
    logic w_perr_unused;
    assign w_perr_unused = w_perr;
    assign rd_perr       = 1'b0;
`endif

    assign mem_men  = r_mem_men;
    assign mem_wen  = r_mem_wen;
    assign mem_ren  = r_rd_pipe[0];
    assign mem_addr = r_mem_addr;
    assign mem_din  = r_mem_din;
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;

endmodule
